data_mem_pipe: RTL and testbench

DATA_MEM_PIPE -- requirements
Module: data_mem_pipe

---
 rtl/data_mem_pipe.sv | 142 ++++++++++++++
 tb/tb_data_mem_pipe.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_pipe.sv
// Byte-strobed single-port data memory with a power-up clear sequence
// and a 1- or 2-stage registered read path.
module data_mem_pipe #(
    parameter int DBITS          = 32,
    parameter int ABITS          = 10,
    parameter int DEPTH          = 1 << ABITS,
    parameter int RD_LAT         = 1,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req,
    input  logic                 we,
    input  logic [DBITS/8-1:0]   be,
    input  logic [ABITS-1:0]     addr,
    input  logic [DBITS-1:0]     din,
    output logic                 ready,
    output logic                 rvalid,
    output logic [DBITS-1:0]     dout,
    output logic                 err,
    output logic                 init_done
);

    localparam int NB = DBITS / 8;
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ABITS:0] LIM  = (ABITS + 1)'(DEPTH);
    localparam logic [IW-1:0]  LAST = IW'(DEPTH - 1);

    typedef enum logic {
        INIT,
        RUN
    } state_t;

    state_t state, state_next;

    logic [IW-1:0]    cnt;
    logic [DBITS-1:0] mem [DEPTH];
    logic             run;
    logic             accept;
    logic             rd_acc;
    logic             wr_acc;
    logic             in_range;
    logic             init_we;
    logic [IW-1:0]    idx;
    logic [DBITS-1:0] rd_word;

    logic             v1;
    logic             e1;
    logic [DBITS-1:0] d1;
    logic             werr;

    // Gating with rst_n keeps ready low while reset is held, even when
    // the block comes out of reset straight into RUN.
    assign run       = (state == RUN) && rst_n;
    assign ready     = run;
    assign init_done = run;
    assign accept    = req && run;
    assign rd_acc    = accept && !we;
    assign wr_acc    = accept && we;
    assign in_range  = {1'b0, addr} < LIM;
    assign idx       = addr[IW-1:0];
    assign rd_word   = in_range ? mem[idx] : '0;
    assign init_we   = (state == INIT) && rst_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= CLEAR_ON_RESET ? INIT : RUN;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            INIT: if (cnt == LAST) state_next = RUN;
            RUN:  state_next = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (state == INIT) begin
            cnt <= cnt + IW'(1);
        end
    end

    // The array has no reset: only the INIT sweep clears it.
    always_ff @(posedge clk) begin
        if (init_we) begin
            mem[cnt] <= '0;
        end else if (wr_acc && in_range) begin
            for (int i = 0; i < NB; i++) begin
                if (be[i]) mem[idx][8*i +: 8] <= din[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1   <= 1'b0;
            e1   <= 1'b0;
            d1   <= '0;
            werr <= 1'b0;
        end else begin
            v1   <= rd_acc;
            e1   <= rd_acc && !in_range;
            werr <= wr_acc && !in_range;
            if (rd_acc) d1 <= rd_word;
        end
    end

    generate
        if (RD_LAT == 2) begin : g_lat2
            logic             v2;
            logic             e2;
            logic [DBITS-1:0] d2;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    v2 <= 1'b0;
                    e2 <= 1'b0;
                    d2 <= '0;
                end else begin
                    v2 <= v1;
                    e2 <= e1;
                    if (v1) d2 <= d1;
                end
            end

            assign rvalid = v2;
            assign dout   = d2;
            assign err    = e2 || werr;
        end else begin : g_lat1
            assign rvalid = v1;
            assign dout   = d1;
            assign err    = e1 || werr;
        end
    endgenerate

endmodule

// File: tb/tb_data_mem_pipe.sv
// Directed bench for data_mem_pipe: two instances (read latency 1 and 2)
// share one stimulus stream; DEPTH=16 with a 5-bit address.
module tb_data_mem_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [4:0]  addr;
    logic [31:0] din;

    logic        ready1, rvalid1, err1, done1;
    logic [31:0] dout1;
    logic        ready2, rvalid2, err2, done2;
    logic [31:0] dout2;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    data_mem_pipe #(
        .DBITS(32), .ABITS(5), .DEPTH(16), .RD_LAT(1), .CLEAR_ON_RESET(1'b1)
    ) dut1 (
        .clk(clk), .rst_n(rst_n), .req(req), .we(we), .be(be),
        .addr(addr), .din(din), .ready(ready1), .rvalid(rvalid1),
        .dout(dout1), .err(err1), .init_done(done1)
    );

    data_mem_pipe #(
        .DBITS(32), .ABITS(5), .DEPTH(16), .RD_LAT(2), .CLEAR_ON_RESET(1'b1)
    ) dut2 (
        .clk(clk), .rst_n(rst_n), .req(req), .we(we), .be(be),
        .addr(addr), .din(din), .ready(ready2), .rvalid(rvalid2),
        .dout(dout2), .err(err2), .init_done(done2)
    );

    typedef struct {
        logic        we;
        logic [3:0]  be;
        logic [4:0]  addr;
        logic [31:0] din;
        logic [31:0] rd;
        logic        err;
    } vec_t;

    localparam int N = 23;
    vec_t ops [N];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Drive one read, then check both instances at their own latency.
    task automatic do_read(input logic [4:0] a, input logic [31:0] exp_d,
                           input logic exp_e, input string tag);
        req  = 1'b1;
        we   = 1'b0;
        addr = a;
        @(negedge clk);
        req = 1'b0;
        chk({tag, "_rv1"}, rvalid1, 1'b1);
        chk({tag, "_d1"}, dout1, exp_d);
        chk({tag, "_e1"}, err1, exp_e);
        chk({tag, "_rv2_early"}, rvalid2, 1'b0);
        @(negedge clk);
        chk({tag, "_rv2"}, rvalid2, 1'b1);
        chk({tag, "_d2"}, dout2, exp_d);
        chk({tag, "_e2"}, err2, exp_e);
        chk({tag, "_rv1_late"}, rvalid1, 1'b0);
    endtask

    // Counts cycles from reset release until ready, bounded.
    task automatic wait_init(output int n, output int seen);
        n    = 0;
        seen = 0;
        while (!ready1 && n < 40) begin
            if (rvalid1 || rvalid2) seen++;
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        logic [31:0] last1, last2;
        logic        rv1e, rv2e, er1e, er2e;
        int          n, seen;

        ops[0]  = '{1'b0, 4'h0, 5'd5,  32'h0,        32'h0,        1'b0};
        ops[1]  = '{1'b1, 4'hF, 5'd3,  32'hAABBCCDD, 32'h0,        1'b0};
        ops[2]  = '{1'b1, 4'h5, 5'd3,  32'h11223344, 32'h0,        1'b0};
        ops[3]  = '{1'b0, 4'h0, 5'd3,  32'h0,        32'hAA22CC44, 1'b0};
        ops[4]  = '{1'b1, 4'hF, 5'd0,  32'h10,       32'h0,        1'b0};
        ops[5]  = '{1'b1, 4'hF, 5'd1,  32'h11,       32'h0,        1'b0};
        ops[6]  = '{1'b1, 4'hF, 5'd2,  32'h12,       32'h0,        1'b0};
        ops[7]  = '{1'b0, 4'h0, 5'd0,  32'h0,        32'h10,       1'b0};
        ops[8]  = '{1'b0, 4'h0, 5'd1,  32'h0,        32'h11,       1'b0};
        ops[9]  = '{1'b0, 4'h0, 5'd2,  32'h0,        32'h12,       1'b0};
        ops[10] = '{1'b1, 4'hF, 5'd20, 32'hFFFFFFFF, 32'h0,        1'b1};
        ops[11] = '{1'b0, 4'h0, 5'd20, 32'h0,        32'h0,        1'b1};
        ops[12] = '{1'b0, 4'h0, 5'd4,  32'h0,        32'h0,        1'b0};
        ops[13] = '{1'b1, 4'hF, 5'd7,  32'hDEADBEEF, 32'h0,        1'b0};
        ops[14] = '{1'b0, 4'h0, 5'd7,  32'h0,        32'hDEADBEEF, 1'b0};
        ops[15] = '{1'b1, 4'h0, 5'd15, 32'h12345678, 32'h0,        1'b0};
        ops[16] = '{1'b0, 4'h0, 5'd15, 32'h0,        32'h0,        1'b0};
        ops[17] = '{1'b1, 4'h8, 5'd15, 32'h12345678, 32'h0,        1'b0};
        ops[18] = '{1'b0, 4'h0, 5'd15, 32'h0,        32'h12000000, 1'b0};
        ops[19] = '{1'b0, 4'h0, 5'd16, 32'h0,        32'h0,        1'b1};
        ops[20] = '{1'b0, 4'h0, 5'd31, 32'h0,        32'h0,        1'b1};
        ops[21] = '{1'b1, 4'hF, 5'd16, 32'hCAFEF00D, 32'h0,        1'b1};
        ops[22] = '{1'b0, 4'h0, 5'd0,  32'h0,        32'h10,       1'b0};

        rst_n = 1'b0;
        req   = 1'b0;
        we    = 1'b0;
        be    = 4'h0;
        addr  = 5'd0;
        din   = 32'h0;
        repeat (2) @(negedge clk);

        chk("rst_ready1", ready1, 1'b0);
        chk("rst_ready2", ready2, 1'b0);
        chk("rst_rvalid1", rvalid1, 1'b0);
        chk("rst_rvalid2", rvalid2, 1'b0);
        chk("rst_err1", err1, 1'b0);
        chk("rst_dout1", dout1, 32'h0);
        chk("rst_dout2", dout2, 32'h0);
        chk("rst_done1", done1, 1'b0);

        // INIT: requests must be ignored; late writes to word 5 must not land.
        rst_n = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("init_ready[%0d]", i), ready1, 1'b0);
            chk($sformatf("init_rv[%0d]", i), rvalid1 | rvalid2, 1'b0);
            req  = 1'b1;
            we   = (i >= 8);
            be   = 4'hF;
            addr = 5'd5;
            din  = 32'hFFFFFFFF;
            @(negedge clk);
        end
        chk("run_ready1", ready1, 1'b1);
        chk("run_ready2", ready2, 1'b1);
        chk("run_done1", done1, 1'b1);
        chk("run_done2", done2, 1'b1);

        last1 = 32'h0;
        last2 = 32'h0;
        for (int k = 0; k < N + 2; k++) begin
            rv1e = 1'b0;
            er1e = 1'b0;
            rv2e = 1'b0;
            er2e = 1'b0;
            if (k >= 1 && k <= N) begin
                rv1e = !ops[k-1].we;
                er1e = ops[k-1].err;
                if (rv1e) last1 = ops[k-1].rd;
                if (ops[k-1].we) er2e = ops[k-1].err;
            end
            if (k >= 2) begin
                rv2e = !ops[k-2].we;
                if (rv2e) begin
                    last2 = ops[k-2].rd;
                    er2e  = er2e | ops[k-2].err;
                end
            end
            chk($sformatf("rv1[%0d]", k), rvalid1, rv1e);
            chk($sformatf("err1[%0d]", k), err1, er1e);
            chk($sformatf("dout1[%0d]", k), dout1, last1);
            chk($sformatf("rv2[%0d]", k), rvalid2, rv2e);
            chk($sformatf("err2[%0d]", k), err2, er2e);
            chk($sformatf("dout2[%0d]", k), dout2, last2);
            chk($sformatf("ready[%0d]", k), ready1 & ready2, 1'b1);
            if (k < N) begin
                req  = 1'b1;
                we   = ops[k].we;
                be   = ops[k].be;
                addr = ops[k].addr;
                din  = ops[k].din;
            end else begin
                req = 1'b0;
            end
            @(negedge clk);
        end

        // Reset one cycle after a read is accepted: nothing may emerge.
        req  = 1'b1;
        we   = 1'b0;
        addr = 5'd7;
        @(negedge clk);
        req   = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("mid_rd_rv1", rvalid1, 1'b0);
        chk("mid_rd_rv2", rvalid2, 1'b0);
        chk("mid_rd_dout1", dout1, 32'h0);
        chk("mid_rd_dout2", dout2, 32'h0);
        chk("mid_rd_ready", ready1 | ready2, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Abort INIT at count 8, then expect a full 16-cycle rerun.
        repeat (8) @(negedge clk);
        chk("abort_ready", ready1, 1'b0);
        chk("abort_no_rv", rvalid1 | rvalid2, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        wait_init(n, seen);
        chk("init_len", n, 16);
        chk("init_no_rv", seen, 0);
        chk("init_ready2", ready2, 1'b1);
        chk("init_done2", done2, 1'b1);

        do_read(5'd7,  32'h0, 1'b0, "clr7");
        do_read(5'd15, 32'h0, 1'b0, "clr15");
        do_read(5'd20, 32'h0, 1'b1, "oob20");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
